// File: rtl/csr_file_pkg.sv
// Shared definitions for the machine-mode CSR file: CSR addresses, mstatus
// bit positions, the MPP constant, trap cause codes, and the mstatus view helper.
package csr_file_pkg;

  // Implemented CSR addresses
  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET = 12'hB02;

  // mstatus field positions
  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;
  localparam int MSTATUS_MPP_LO   = 11;

  // Only machine mode exists, so MPP always reads back as M
  localparam logic [1:0] MSTATUS_MPP_RESET = 2'b11;

  // Trap cause codes
  localparam logic [63:0] CAUSE_MISALIGNED_FETCH = 64'd0;
  localparam logic [63:0] CAUSE_ILLEGAL_INSN     = 64'd2;
  localparam logic [63:0] CAUSE_BREAKPOINT       = 64'd3;
  localparam logic [63:0] CAUSE_ECALL_M          = 64'd11;

  // The only writable mstatus state
  typedef struct packed {
    logic mpie;
    logic mie;
  } mstatus_t;

  // Architectural view of mstatus: stored bits plus the constant MPP field
  function automatic logic [63:0] mstatus_view(mstatus_t s);
    logic [63:0] v;
    v = '0;
    v[MSTATUS_MIE_BIT]                      = s.mie;
    v[MSTATUS_MPIE_BIT]                     = s.mpie;
    v[MSTATUS_MPP_LO+1:MSTATUS_MPP_LO]      = MSTATUS_MPP_RESET;
    return v;
  endfunction

endpackage

// File: rtl/csr_file_if.sv
// Pipeline <-> CSR file signal bundle. master = pipeline side, slave = csr_file.
// There is no handshake: every input is a single-cycle strobe/value qualified
// by the rising clock edge, and every output is combinational from the current
// inputs and register state.
interface csr_file_if;
  logic        csr_wen_i;
  logic [11:0] csr_addr_i;
  logic [63:0] csr_wdata_i;
  logic        exception_i;
  logic [63:0] pc_i;
  logic [63:0] mcause_i;
  logic        mret_i;
  logic        retire_i;
  logic [11:0] csr_raddr_i;
  logic [63:0] csr_rdata_o;
  logic        illegal_o;
  logic        redirect_o;
  logic [63:0] redirect_pc_o;

  modport master (
    output csr_wen_i, csr_addr_i, csr_wdata_i, exception_i, pc_i, mcause_i,
           mret_i, retire_i, csr_raddr_i,
    input  csr_rdata_o, illegal_o, redirect_o, redirect_pc_o
  );

  modport slave (
    input  csr_wen_i, csr_addr_i, csr_wdata_i, exception_i, pc_i, mcause_i,
           mret_i, retire_i, csr_raddr_i,
    output csr_rdata_o, illegal_o, redirect_o, redirect_pc_o
  );
endinterface

// File: rtl/csr_counter.sv
// 64-bit free-running counter with a synchronous load that wins over increment.
// Wraps from all-ones to zero silently.
module csr_counter (
  input  logic        clock,
  input  logic        reset,
  input  logic        load_i,
  input  logic [63:0] load_val_i,
  input  logic        inc_i,
  output logic [63:0] count_o
);
  logic [63:0] count_q, count_d;

  // Next count: load has priority over increment
  always_comb begin
    count_d = count_q;
    if (load_i)     count_d = load_val_i;
    else if (inc_i) count_d = count_q + 64'd1;
  end

  // Counter register with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count_o = count_q;
endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR file: mstatus, mtvec, mscratch, mepc, mcause, and optional
// mcycle/minstret counters (enabled by defining CSR_COUNTERS_EN). Handles trap
// entry and MRET, and drives the fetch redirect. Update priority is
// reset > exception > mret > CSR write.
module csr_file
  import csr_file_pkg::*;
(
  input logic         clock,
  input logic         reset,
  csr_file_if.slave   bus
);
  mstatus_t    mstatus_q, mstatus_d;
  logic [63:0] mtvec_q, mtvec_d;
  logic [63:0] mscratch_q, mscratch_d;
  logic [63:0] mepc_q, mepc_d;
  logic [63:0] mcause_q, mcause_d;
  logic        wr_en;
  logic        unused_inputs;

  // A CSR write only lands when no trap or MRET claims the cycle
  assign wr_en = bus.csr_wen_i & ~bus.exception_i & ~bus.mret_i;

  // Next-state for the trap-related CSRs
  always_comb begin
    mstatus_d  = mstatus_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    if (bus.exception_i) begin
      mepc_d         = {bus.pc_i[63:2], 2'b00};
      mcause_d       = bus.mcause_i;
      mstatus_d.mpie = mstatus_q.mie;
      mstatus_d.mie  = 1'b0;
    end else if (bus.mret_i) begin
      mstatus_d.mie  = mstatus_q.mpie;
      mstatus_d.mpie = 1'b1;
    end else if (wr_en) begin
      case (bus.csr_addr_i)
        CSR_MSTATUS: begin
          mstatus_d.mie  = bus.csr_wdata_i[MSTATUS_MIE_BIT];
          mstatus_d.mpie = bus.csr_wdata_i[MSTATUS_MPIE_BIT];
        end
        CSR_MTVEC:    mtvec_d    = bus.csr_wdata_i;
        CSR_MSCRATCH: mscratch_d = bus.csr_wdata_i;
        CSR_MEPC:     mepc_d     = {bus.csr_wdata_i[63:2], 2'b00};
        CSR_MCAUSE:   mcause_d   = bus.csr_wdata_i;
        default: ;
      endcase
    end
  end

  // CSR registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      mstatus_q  <= '0;
      mtvec_q    <= '0;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
    end else begin
      mstatus_q  <= mstatus_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
    end
  end

`ifdef CSR_COUNTERS_EN
  logic [63:0] mcycle, minstret;

  csr_counter u_mcycle (
    .clock      (clock),
    .reset      (reset),
    .load_i     (wr_en && bus.csr_addr_i == CSR_MCYCLE),
    .load_val_i (bus.csr_wdata_i),
    .inc_i      (1'b1),
    .count_o    (mcycle)
  );

  csr_counter u_minstret (
    .clock      (clock),
    .reset      (reset),
    .load_i     (wr_en && bus.csr_addr_i == CSR_MINSTRET),
    .load_val_i (bus.csr_wdata_i),
    .inc_i      (bus.retire_i),
    .count_o    (minstret)
  );

  assign unused_inputs = ^bus.pc_i[1:0];
`else
  assign unused_inputs = ^{bus.pc_i[1:0], bus.retire_i};
`endif

  // Combinational read port; shows pre-edge values (no write bypass)
  always_comb begin
    bus.csr_rdata_o = '0;
    bus.illegal_o   = 1'b0;
    case (bus.csr_raddr_i)
      CSR_MSTATUS:  bus.csr_rdata_o = mstatus_view(mstatus_q);
      CSR_MTVEC:    bus.csr_rdata_o = mtvec_q;
      CSR_MSCRATCH: bus.csr_rdata_o = mscratch_q;
      CSR_MEPC:     bus.csr_rdata_o = mepc_q;
      CSR_MCAUSE:   bus.csr_rdata_o = mcause_q;
`ifdef CSR_COUNTERS_EN
      CSR_MCYCLE:   bus.csr_rdata_o = mcycle;
      CSR_MINSTRET: bus.csr_rdata_o = minstret;
`else
      CSR_MCYCLE, CSR_MINSTRET: bus.csr_rdata_o = '0;
`endif
      default:      bus.illegal_o = 1'b1;
    endcase
  end

  // Fetch redirect: trap vector (direct mode) on exception, mepc on MRET
  always_comb begin
    bus.redirect_o    = bus.exception_i | bus.mret_i;
    bus.redirect_pc_o = '0;
    if (bus.exception_i)  bus.redirect_pc_o = {mtvec_q[63:2], 2'b00};
    else if (bus.mret_i)  bus.redirect_pc_o = mepc_q;
  end
endmodule

// File: tb/tb_csr_file.sv
// Self-checking bench for csr_file. Counter checks adapt to CSR_COUNTERS_EN.
module tb_csr_file;
  localparam int W = 65;

  logic clock;
  logic reset;
  csr_file_if bus();

  csr_file dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Clock and reset
  initial clock = 1'b0;
  always #10 clock = ~clock;

  // Scoreboard
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic expect_val(input logic [W-1:0] v);
    exp_q.push_back(v);
  endtask

  task automatic compare(input string name, input logic [W-1:0] act);
    logic [W-1:0] e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: no expected value queued, got %h", name, act);
    end else begin
      e = exp_q.pop_front();
      if (act !== e) begin
        n_fail++;
        $display("FAIL %s: got %h required %h", name, act, e);
      end
    end
  endtask

  // Driver tasks
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    bus.csr_wen_i   = 1'b0;
    bus.csr_addr_i  = '0;
    bus.csr_wdata_i = '0;
    bus.exception_i = 1'b0;
    bus.pc_i        = '0;
    bus.mcause_i    = '0;
    bus.mret_i      = 1'b0;
    bus.retire_i    = 1'b0;
  endtask

  task automatic write_csr(input logic [11:0] addr, input logic [63:0] data);
    bus.csr_wen_i   = 1'b1;
    bus.csr_addr_i  = addr;
    bus.csr_wdata_i = data;
    step();
    idle();
  endtask

  task automatic read_check(input string name, input logic [11:0] addr,
                            input logic [63:0] exp_data, input logic exp_ill);
    bus.csr_raddr_i = addr;
    expect_val({exp_ill, exp_data});
    #1;
    compare(name, {bus.illegal_o, bus.csr_rdata_o});
  endtask

  task automatic redir_check(input string name, input logic exp_r,
                             input logic [63:0] exp_pc);
    expect_val({exp_r, exp_pc});
    #1;
    compare(name, {bus.redirect_o, bus.redirect_pc_o});
  endtask

  task automatic check_reset_values(input string tag);
    read_check({tag, "_mstatus"},  12'h300, 64'h1800, 1'b0);
    read_check({tag, "_mtvec"},    12'h305, 64'h0, 1'b0);
    read_check({tag, "_mscratch"}, 12'h340, 64'h0, 1'b0);
    read_check({tag, "_mepc"},     12'h341, 64'h0, 1'b0);
    read_check({tag, "_mcause"},   12'h342, 64'h0, 1'b0);
    read_check({tag, "_mcycle"},   12'hB00, 64'h0, 1'b0);
    read_check({tag, "_minstret"}, 12'hB02, 64'h0, 1'b0);
  endtask

  // Write-then-read vector table
  typedef struct {
    logic [11:0] addr;
    logic [63:0] wdata;
    logic [63:0] exp_rdata;
    logic        exp_ill;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [63:0] r;
    logic [63:0] prev;

    vecs[0] = '{12'h340, 64'hDEADBEEF_CAFEF00D, 64'hDEADBEEF_CAFEF00D, 1'b0};
    vecs[1] = '{12'h305, 64'h12345678_9ABCDEF1, 64'h12345678_9ABCDEF1, 1'b0};
    vecs[2] = '{12'h341, 64'h00000000_80000003, 64'h00000000_80000000, 1'b0};
    vecs[3] = '{12'h342, 64'h80000000_00000007, 64'h80000000_00000007, 1'b0};
    vecs[4] = '{12'h300, 64'hFFFFFFFF_FFFFFFFF, 64'h00000000_00001888, 1'b0};
    vecs[5] = '{12'h300, 64'h00000000_00000000, 64'h00000000_00001800, 1'b0};
    vecs[6] = '{12'h7C0, 64'h00000000_00000005, 64'h0, 1'b1};
    vecs[7] = '{12'h301, 64'h00000000_0000FFFF, 64'h0, 1'b1};

    idle();
    bus.csr_raddr_i = '0;
    reset = 1'b1;
    repeat (3) step();
    check_reset_values("reset");
    reset = 1'b0;
    redir_check("idle_redirect", 1'b0, 64'h0);

    // Table-driven write/readback
    for (int i = 0; i < 8; i++) begin
      write_csr(vecs[i].addr, vecs[i].wdata);
      read_check($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp_rdata,
                 vecs[i].exp_ill);
    end
    read_check("mscratch_kept", 12'h340, 64'hDEADBEEF_CAFEF00D, 1'b0);

    // Random mscratch traffic, also checking the read shows the pre-edge value
    prev = 64'hDEADBEEF_CAFEF00D;
    for (int i = 0; i < 4; i++) begin
      r = {$urandom(), $urandom()};
      bus.csr_wen_i   = 1'b1;
      bus.csr_addr_i  = 12'h340;
      bus.csr_wdata_i = r;
      read_check($sformatf("no_bypass%0d", i), 12'h340, prev, 1'b0);
      step();
      idle();
      read_check($sformatf("rand_mscratch%0d", i), 12'h340, r, 1'b0);
      prev = r;
    end

    // Trap entry
    write_csr(12'h305, 64'h80001003);
    bus.exception_i = 1'b1;
    bus.pc_i        = 64'h80000104;
    bus.mcause_i    = 64'd11;
    redir_check("exc_redirect", 1'b1, 64'h80001000);
    step();
    idle();
    read_check("exc_mepc",   12'h341, 64'h80000104, 1'b0);
    read_check("exc_mcause", 12'h342, 64'd11, 1'b0);

    // mstatus stack across exception and MRET
    write_csr(12'h300, 64'h8);
    read_check("mstatus_mie", 12'h300, 64'h1808, 1'b0);
    bus.exception_i = 1'b1;
    bus.pc_i        = 64'h80000200;
    bus.mcause_i    = 64'd2;
    step();
    idle();
    read_check("mstatus_after_exc", 12'h300, 64'h1880, 1'b0);
    bus.mret_i = 1'b1;
    redir_check("mret_redirect", 1'b1, 64'h80000200);
    step();
    idle();
    read_check("mstatus_after_mret", 12'h300, 64'h1888, 1'b0);

    // Exception beats a same-cycle mepc write; pc low bits dropped
    bus.exception_i = 1'b1;
    bus.pc_i        = 64'h80000407;
    bus.mcause_i    = 64'd3;
    bus.csr_wen_i   = 1'b1;
    bus.csr_addr_i  = 12'h341;
    bus.csr_wdata_i = 64'h1234;
    step();
    idle();
    read_check("exc_over_wen", 12'h341, 64'h80000404, 1'b0);

    // MRET beats a same-cycle mscratch write
    write_csr(12'h340, 64'h55);
    bus.mret_i      = 1'b1;
    bus.csr_wen_i   = 1'b1;
    bus.csr_addr_i  = 12'h340;
    bus.csr_wdata_i = 64'hAA;
    step();
    idle();
    read_check("mret_over_wen", 12'h340, 64'h55, 1'b0);

`ifdef CSR_COUNTERS_EN
    // Counter load and wrap
    write_csr(12'hB00, 64'hFFFFFFFF_FFFFFFFF);
    read_check("mcycle_ones", 12'hB00, 64'hFFFFFFFF_FFFFFFFF, 1'b0);
    step();
    read_check("mcycle_wrap", 12'hB00, 64'h0, 1'b0);
    write_csr(12'hB02, 64'h0);
    bus.retire_i = 1'b1;
    repeat (3) step();
    bus.retire_i = 1'b0;
    read_check("minstret_3", 12'hB02, 64'd3, 1'b0);
    bus.retire_i = 1'b1;
    write_csr(12'hB02, 64'd100);
    read_check("minstret_load_wins", 12'hB02, 64'd100, 1'b0);
`else
    write_csr(12'hB00, 64'hFFFFFFFF_FFFFFFFF);
    read_check("mcycle_absent", 12'hB00, 64'h0, 1'b0);
    bus.retire_i = 1'b1;
    write_csr(12'hB02, 64'h7);
    read_check("minstret_absent", 12'hB02, 64'h0, 1'b0);
`endif

    // Reset coincident with exception, MRET and a write
    write_csr(12'h305, 64'h2000);
    write_csr(12'h300, 64'h88);
    bus.exception_i = 1'b1;
    bus.mret_i      = 1'b1;
    bus.pc_i        = 64'h9000;
    bus.mcause_i    = 64'd11;
    bus.csr_wen_i   = 1'b1;
    bus.csr_addr_i  = 12'h340;
    bus.csr_wdata_i = 64'h77;
    bus.retire_i    = 1'b1;
    reset           = 1'b1;
    redir_check("reset_redirect_comb", 1'b1, 64'h2000);
    step();
    reset = 1'b0;
    idle();
    check_reset_values("reset_exc");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/csr_file.md
CSR_FILE -- requirements
Module: csr_file

Interface
REQ-001 SHALL have ports: clock  in  1  single clock, all state updates on rising edge.
REQ-002 SHALL have ports: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have ports: csr_wen_i  in  1  CSR write enable from writeback.
REQ-004 SHALL have ports: csr_addr_i  in  12  CSR write address.
REQ-005 SHALL have ports: csr_wdata_i  in  64  CSR write data.
REQ-006 SHALL have ports: exception_i  in  1  trap taken at writeback.
REQ-007 SHALL have ports: pc_i  in  64  PC of the trapping instruction.
REQ-008 SHALL have ports: mcause_i  in  64  cause code of the trap.
REQ-009 SHALL have ports: mret_i  in  1  MRET retiring at writeback.
REQ-010 SHALL have ports: retire_i  in  1  one instruction retired this cycle.
REQ-011 SHALL have ports: csr_raddr_i  in  12  CSR read address from execute.
REQ-012 SHALL have ports: csr_rdata_o  out  64  read data.
REQ-013 SHALL have ports: illegal_o  out  1  csr_raddr_i is not an implemented CSR.
REQ-014 SHALL have ports: redirect_o  out  1  ifetch must redirect.
REQ-015 SHALL have ports: redirect_pc_o  out  64  redirect target.

Function
REQ-016 SHALL implement these CSRs: mstatus 0x300, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mcycle 0xB00, minstret 0xB02.
REQ-017 SHALL read combinationally: csr_rdata_o shows the pre-edge register value, with no write bypass.
REQ-018 SHALL return 0 and assert illegal_o for an unimplemented read address.
REQ-019 SHALL make only mstatus bits MIE[3], MPIE[7] and MPP[12:11] stored; MPP reads constant 2'b11; all other mstatus bits read 0.
REQ-020 SHALL force mepc[1:0] to 0 on every write, both CSR writes and trap writes.
REQ-021 SHALL on exception_i at an edge: mepc<=pc_i, mcause<=mcause_i, MPIE<=MIE, MIE<=0.
REQ-022 SHALL on mret_i at an edge: MIE<=MPIE, MPIE<=1.
REQ-023 SHALL drive redirect_o combinationally, the same cycle, as exception_i | mret_i.
REQ-024 SHALL drive redirect_pc_o as {mtvec[63:2],2'b00} on exception (direct mode only) and as current mepc on mret; 0 otherwise.
REQ-025 SHALL apply priority exception_i > mret_i > csr_wen_i; a lower-priority update is dropped in the same cycle.
REQ-026 SHALL increment mcycle by 1 every non-reset cycle; a CSR write to mcycle that cycle loads the written value instead, with no increment.
REQ-027 SHALL increment minstret when retire_i is high; a CSR write to minstret that cycle wins over the increment.
REQ-028 SHALL let both counters wrap modulo 2^64 from all-ones to 0 with no flag.
REQ-029 SHALL silently ignore writes to unimplemented addresses.

Reset
REQ-030 SHALL during reset set: mstatus stored bits 0 (reads 0x1800), mtvec/mscratch/mepc/mcause/mcycle/minstret 0.
REQ-031 SHALL make reset override exception_i, mret_i and csr_wen_i in the same cycle; redirect_o still follows the inputs combinationally.

Configuration
REQ-032 SHALL with macro CSR_COUNTERS_EN defined implement mcycle and minstret per REQ-026..028.
REQ-033 SHALL with CSR_COUNTERS_EN undefined have no counter flops: 0xB00/0xB02 read 0, illegal_o=0 for them, writes ignored.

Structure
REQ-034 SHALL keep CSR address constants, mstatus bit positions and the MPP reset constant in the shared define header, alongside the cause codes.
REQ-035 SHALL instantiate sub-module csr_counter (64-bit, load and inc inputs, load over inc) twice for mcycle/minstret, only when CSR_COUNTERS_EN is defined.

Verification
REQ-036 SHALL cover: write mtvec=0x80001003, then exception_i with pc_i=0x80000104, mcause_i=11 -> redirect_o=1, redirect_pc_o=0x80001000 same cycle; next cycle mepc=0x80000104, mcause=11.
REQ-037 SHALL cover: mstatus written 0x8, exception, then mret_i -> after exception mstatus reads 0x1880; after mret reads 0x1888; redirect_pc_o=mepc during mret.
REQ-038 SHALL cover: same-cycle exception_i and csr_wen_i to mepc with data 0x1234 -> mepc=pc_i, 0x1234 discarded.
REQ-039 SHALL cover: write mcycle=0xFFFFFFFFFFFFFFFF -> reads all-ones next cycle, 0 the cycle after; minstret with retire_i held 3 cycles -> 3.
REQ-040 SHALL cover: read 0x7C0 -> csr_rdata_o=0, illegal_o=1; mepc written 0x80000003 -> reads 0x80000000.
REQ-041 SHALL cover: reset asserted coincident with exception_i -> all CSRs at reset values after the edge; counters 0 with CSR_COUNTERS_EN both defined and undefined.
